// File: rtl/stepper_ctrl.sv
// Memory-mapped stepper-motor controller: register file on the dmem bus plus a coil-phase sequencer.
// Optional end-of-travel limit switches are built when STEPPER_LIMIT_EN is defined.
module stepper_ctrl #(
  parameter logic [11:0] BASE_ADDR = 12'hF00,
  parameter int unsigned PERIOD_W  = 24,
  parameter int unsigned STEPS_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
`ifdef STEPPER_LIMIT_EN
  input  logic [1:0]  limit,
`endif
  output logic        hit,
  output logic [31:0] q_periph,
  output logic [3:0]  coil,
  output logic        drv_en,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e               state_q, state_d;
  logic                 dir_q, dir_d, half_q, half_d, hold_q, hold_d;
  logic                 done_q, done_d, aborted_q, aborted_d;
  logic [STEPS_W-1:0]   steps_q, steps_d, rem_q, rem_d;
  logic [PERIOD_W-1:0]  period_q, period_d, cnt_q, cnt_d, eff_period;
  logic [31:0]          pos_q, pos_d;
  logic [2:0]           phase_q, phase_d, phase_step, off;
  logic [3:0]           pattern;
  logic                 run;
  logic                 wr_ctrl, wr_steps, wr_period, wr_status, wr_pos;
  logic [1:0]           lim_sync;
  logic                 lim_run, lim_start;

  // 13-bit compare so a base near the top of the map cannot wrap around.
  assign hit = ({1'b0, address_dmem} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, address_dmem} <= ({1'b0, BASE_ADDR} + 13'd4));
  assign off = address_dmem[2:0] - BASE_ADDR[2:0];

  assign wr_ctrl   = wren && hit && (off == 3'd0);
  assign wr_steps  = wren && hit && (off == 3'd1);
  assign wr_period = wren && hit && (off == 3'd2);
  assign wr_status = wren && hit && (off == 3'd3);
  assign wr_pos    = wren && hit && (off == 3'd4);

  assign run        = (state_q == StRun);
  assign eff_period = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;
  assign phase_step = half_q ? 3'd1 : 3'd2;

`ifdef STEPPER_LIMIT_EN
  logic [1:0] lim_meta_q, lim_sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lim_meta_q <= 2'b00;
      lim_sync_q <= 2'b00;
    end else begin
      lim_meta_q <= limit;
      lim_sync_q <= lim_meta_q;
    end
  end

  assign lim_sync  = lim_sync_q;
  assign lim_run   = dir_q ? lim_sync_q[0] : lim_sync_q[1];
  assign lim_start = data[1] ? lim_sync_q[0] : lim_sync_q[1];
`else
  assign lim_sync  = 2'b00;
  assign lim_run   = 1'b0;
  assign lim_start = 1'b0;
`endif

  always_comb begin
    case (phase_q)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1100;
      3'd2:    pattern = 4'b0100;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0010;
      3'd5:    pattern = 4'b0011;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    half_d    = half_q;
    hold_d    = hold_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    steps_d   = steps_q;
    period_d  = period_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;

    if (!run) begin
      if (wr_steps)  steps_d  = data[STEPS_W-1:0];
      if (wr_period) period_d = data[PERIOD_W-1:0];
      if (wr_pos)    pos_d    = data;
    end
    if (wr_status) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (wr_ctrl && data[0]) begin
          dir_d  = data[1];
          half_d = data[2];
          hold_d = data[4];
          if (lim_start) begin
            aborted_d = 1'b1;
          end else if (steps_q == '0) begin
            state_d = StFinish;
          end else begin
            rem_d   = steps_q;
            cnt_d   = eff_period;
            // Full-step runs stay on the two-coil (odd) patterns.
            if (!data[2]) phase_d = phase_q | 3'd1;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if ((wr_ctrl && data[3]) || lim_run) begin
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (cnt_q == PERIOD_W'(1)) begin
          phase_d = dir_q ? (phase_q + phase_step) : (phase_q - phase_step);
          pos_d   = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
          cnt_d   = eff_period;
          if (rem_q != '0) rem_d = rem_q - STEPS_W'(1);
          if (rem_q <= STEPS_W'(1)) state_d = StFinish;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      steps_q   <= '0;
      period_q  <= '0;
      pos_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= 3'd1;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      steps_q   <= steps_d;
      period_q  <= period_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign busy   = run;
  // The finishing cycle still drives the final pattern so the last step is visible.
  assign drv_en = (state_q != StIdle) || hold_q;
  assign coil   = drv_en ? pattern : 4'b0000;

  always_comb begin
    q_periph = '0;
    if (hit) begin
      case (off)
        3'd0:    q_periph = {27'b0, hold_q, 1'b0, half_q, dir_q, 1'b0};
        3'd1:    q_periph = 32'(steps_q);
        3'd2:    q_periph = 32'(period_q);
        3'd3:    q_periph = {16'(rem_q), 11'b0, lim_sync, aborted_q, done_q, busy};
        3'd4:    q_periph = pos_q;
        default: q_periph = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Directed self-checking bench for stepper_ctrl; builds the limit-switch checks when
// STEPPER_LIMIT_EN is defined.
module tb_stepper_ctrl;

  localparam logic [11:0] ACtrl   = 12'hF00;
  localparam logic [11:0] ASteps  = 12'hF01;
  localparam logic [11:0] APeriod = 12'hF02;
  localparam logic [11:0] AStatus = 12'hF03;
  localparam logic [11:0] APos    = 12'hF04;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        hit;
  logic [31:0] q_periph;
  logic [3:0]  coil;
  logic        drv_en;
  logic        busy;
`ifdef STEPPER_LIMIT_EN
  logic [1:0]  limit;
`endif

  int total = 0;
  int bad   = 0;

  stepper_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
`ifdef STEPPER_LIMIT_EN
    .limit        (limit),
`endif
    .hit          (hit),
    .q_periph     (q_periph),
    .coil         (coil),
    .drv_en       (drv_en),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Store lands on the next rising edge; returns 1 time unit after that edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    @(posedge clock);
    #1;
    wren         = 1'b0;
    address_dmem = 12'h000;
    data         = 32'h0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    address_dmem = a;
    #1;
    chk(tag, q_periph, exp);
    address_dmem = 12'h000;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    wren         = 1'b0;
    address_dmem = 12'h000;
    data         = 32'h0;
`ifdef STEPPER_LIMIT_EN
    limit        = 2'b00;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Reset state and address decode.
    chk("rst_coil", 32'(coil), 32'h0);
    chk("rst_drv_en", 32'(drv_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("miss_hit", 32'(hit), 32'h0);
    chk("miss_q", q_periph, 32'h0);
    rd(ACtrl, 32'h0, "rst_ctrl");
    rd(ASteps, 32'h0, "rst_steps");
    rd(APeriod, 32'h0, "rst_period");
    rd(AStatus, 32'h0, "rst_status");
    rd(APos, 32'h0, "rst_pos");
    address_dmem = 12'hF05;
    #1;
    chk("hit_above", 32'(hit), 32'h0);

    // Full-step forward with hold, plus busy protection mid-run.
    wr(ASteps, 32'd4);
    wr(APeriod, 32'd10);
    wr(ACtrl, 32'h13);
    chk("fs_busy", 32'(busy), 32'h1);
    chk("fs_drv_en", 32'(drv_en), 32'h1);
    chk("fs_coil0", 32'(coil), 32'b1100);
    rd(ACtrl, 32'h12, "fs_ctrl_rd");
    rd(AStatus, 32'h0004_0001, "fs_status_run");
    cyc(9);
    chk("fs_coil_e9", 32'(coil), 32'b1100);
    cyc(1);
    chk("fs_coil_e10", 32'(coil), 32'b0110);
    wr(APeriod, 32'd99);
    wr(APos, 32'h55);
    wr(ACtrl, 32'h13);
    wr(ASteps, 32'd7);
    rd(APeriod, 32'd10, "bp_period");
    rd(ASteps, 32'd4, "bp_steps");
    rd(APos, 32'd1, "bp_pos");
    rd(AStatus, 32'h0003_0001, "bp_status");
    cyc(5);
    chk("fs_coil_e19", 32'(coil), 32'b0110);
    cyc(1);
    chk("fs_coil_e20", 32'(coil), 32'b0011);
    cyc(10);
    chk("fs_coil_e30", 32'(coil), 32'b1001);
    cyc(10);
    chk("fs_coil_e40", 32'(coil), 32'b1100);
    chk("fs_busy_end", 32'(busy), 32'h0);
    cyc(1);
    rd(AStatus, 32'h0000_0002, "fs_done");
    rd(APos, 32'd4, "fs_pos");
    chk("fs_hold_coil", 32'(coil), 32'b1100);
    chk("fs_hold_drv", 32'(drv_en), 32'h1);
    wr(AStatus, 32'h0);
    rd(AStatus, 32'h0, "status_clear");

    // Half-step reverse, period clamped to 2, no hold.
    wr(APos, 32'd100);
    wr(ASteps, 32'd3);
    wr(APeriod, 32'd0);
    wr(ACtrl, 32'h05);
    chk("hs_coil0", 32'(coil), 32'b1100);
    cyc(1);
    chk("hs_coil_e1", 32'(coil), 32'b1100);
    cyc(1);
    chk("hs_coil_e2", 32'(coil), 32'b1000);
    cyc(2);
    chk("hs_coil_e4", 32'(coil), 32'b1001);
    cyc(2);
    chk("hs_coil_e6", 32'(coil), 32'b0001);
    chk("hs_busy_end", 32'(busy), 32'h0);
    cyc(1);
    chk("hs_coil_idle", 32'(coil), 32'b0000);
    chk("hs_drv_idle", 32'(drv_en), 32'h0);
    rd(APos, 32'd97, "hs_pos");
    rd(AStatus, 32'h0000_0002, "hs_done");
    wr(AStatus, 32'h0);

    // Abort after the 7th step of a long run.
    wr(APos, 32'd0);
    wr(ASteps, 32'd1000);
    wr(APeriod, 32'd5);
    wr(ACtrl, 32'h03);
    chk("ab_coil0", 32'(coil), 32'b1001);
    cyc(35);
    rd(APos, 32'd7, "ab_pos_pre");
    chk("ab_coil_pre", 32'(coil), 32'b0011);
    wr(ACtrl, 32'h08);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_coil", 32'(coil), 32'b0000);
    rd(AStatus, 32'h03E1_0004, "ab_status");
    cyc(10);
    rd(APos, 32'd7, "ab_pos_still");
    wr(AStatus, 32'h0);

    // Zero-step start finishes without motion.
    wr(ASteps, 32'd0);
    wr(ACtrl, 32'h01);
    chk("zs_busy", 32'(busy), 32'h0);
    cyc(1);
    address_dmem = AStatus;
    #1;
    chk("zs_done", q_periph & 32'h0000_FFFF, 32'h2);
    wr(AStatus, 32'h0);

    // Position wraps past +2^31-1.
    wr(APos, 32'h7FFF_FFFF);
    wr(ASteps, 32'd1);
    wr(APeriod, 32'd2);
    wr(ACtrl, 32'h03);
    cyc(3);
    rd(APos, 32'h8000_0000, "wrap_pos");
    rd(AStatus, 32'h0000_0002, "wrap_done");
    wr(AStatus, 32'h0);

`ifdef STEPPER_LIMIT_EN
    // Forward limit hit mid-run, then a start toward the asserted limit.
    wr(ASteps, 32'd50);
    wr(APeriod, 32'd4);
    wr(ACtrl, 32'h03);
    cyc(80);
    rd(APos, 32'h8000_0014, "lim_pos");
    limit = 2'b01;
    cyc(3);
    chk("lim_busy", 32'(busy), 32'h0);
    rd(AStatus, 32'h001E_000C, "lim_status");
    wr(AStatus, 32'h0);
    rd(AStatus, 32'h001E_0008, "lim_clr");
    wr(ACtrl, 32'h03);
    chk("lim_start_busy", 32'(busy), 32'h0);
    chk("lim_start_coil", 32'(coil), 32'b0000);
    rd(AStatus, 32'h001E_000C, "lim_start_status");
    cyc(4);
    rd(APos, 32'h8000_0014, "lim_pos_hold");
    limit = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
